// File: rtl/matmul_loader_pkg.sv
// Shared configuration, derived widths and FSM encoding for the matmul BRAM loader.
package matmul_loader_pkg;

  // Datapath geometry
  localparam int WIDTH        = 16;  // element width in bits
  localparam int CHUNK_SIZE   = 4;   // elements per stream beat
  localparam int NUM_CORES    = 2;   // beats packed per input-BRAM word
  localparam int W_WORDS      = 6;   // weight-BRAM words per load
  localparam int I_WORDS      = 3;   // input-BRAM words per load
  localparam int W_ADDR_WIDTH = 12;
  localparam int I_ADDR_WIDTH = 14;

  // Derived widths
  localparam int BEAT_W = WIDTH * CHUNK_SIZE;
  localparam int WE_W   = BEAT_W / 8;
  localparam int PACK_W = BEAT_W * NUM_CORES;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_W = 2'd1,
    LOAD_I = 2'd2,
    DONE   = 2'd3
  } load_state_e;

endpackage

// File: rtl/matmul_bram_loader_packer.sv
// core_word_packer: shifts NUM_CORES stream beats into one wide input-BRAM word.
// Beat 0 of a word ends up in the LSBs; word_valid pulses for one cycle with the word.
module core_word_packer
  import matmul_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              beat_valid,
  input  logic [BEAT_W-1:0] beat,
  output logic              at_last_slot,
  output logic              word_valid,
  output logic [PACK_W-1:0] word
);

  localparam int CNT_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  logic [CNT_W-1:0]  beat_cnt;
  logic [PACK_W-1:0] shift_q;
  logic [PACK_W-1:0] shift_d;

  // The next beat completes a word when the slot counter sits on the top slot.
  assign at_last_slot = (beat_cnt == CNT_W'(NUM_CORES - 1));
  // New beats enter at the top; after NUM_CORES shifts the first beat is in the LSBs.
  assign shift_d      = {beat, shift_q[PACK_W-1:BEAT_W]};

  // Slot counter and shift register; clear discards any partially packed word.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt <= '0;
      shift_q  <= '0;
    end else if (clear) begin
      beat_cnt <= '0;
      shift_q  <= '0;
    end else if (beat_valid) begin
      shift_q  <= shift_d;
      beat_cnt <= at_last_slot ? '0 : beat_cnt + 1'b1;
    end
  end

  // Registered word output: one-cycle strobe, data holds between words.
  // NOTE: data registers get a reset too because every loader output must read 0 after rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_valid <= 1'b0;
      word       <= '0;
    end else begin
      word_valid <= beat_valid && at_last_slot && !clear;
      if (beat_valid && at_last_slot && !clear) word <= shift_d;
    end
  end

endmodule

// File: rtl/matmul_bram_loader.sv
// matmul_bram_loader: turns one valid/ready beat stream into port-A writes for the
// weight BRAM, then the packed input BRAM, and raises start once both are loaded.
// Optional feature macro: LOADER_LAST_CHECK_EN (s_last framing check driving err).
module matmul_bram_loader
  import matmul_loader_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_req,
  input  logic [BEAT_W-1:0]       s_data,
  input  logic                    s_valid,
  input  logic                    s_last,
  output logic                    s_ready,
  output logic                    wb_ena,
  output logic [WE_W-1:0]         wb_wea,
  output logic [W_ADDR_WIDTH-1:0] wb_addra,
  output logic [BEAT_W-1:0]       wb_dina,
  output logic                    in_ena,
  output logic [WE_W-1:0]         in_wea,
  output logic [I_ADDR_WIDTH-1:0] in_addra,
  output logic [PACK_W-1:0]       in_dina,
  output logic                    start,
  output logic                    err
);

  load_state_e             state_q, state_d;
  logic [W_ADDR_WIDTH-1:0] w_cnt;
  logic [I_ADDR_WIDTH-1:0] i_cnt;
  logic                    start_load, accept_w, accept_i;
  logic                    at_last_slot, word_done, final_beat, pack_clear;
  logic                    last_w_beat, last_i_word;

  assign last_w_beat = (w_cnt == W_ADDR_WIDTH'(W_WORDS - 1));
  assign last_i_word = (i_cnt == I_ADDR_WIDTH'(I_WORDS - 1));
  assign s_ready     = (state_q == LOAD_W) || (state_q == LOAD_I);
  assign word_done   = accept_i && at_last_slot;
  assign final_beat  = word_done && last_i_word;
  assign pack_clear  = (state_q == LOAD_W) && (state_d == LOAD_I);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and beat-acceptance decode.
  // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    start_load = 1'b0;
    accept_w   = 1'b0;
    accept_i   = 1'b0;
    unique case (state_q)
      IDLE, DONE: if (load_req) begin
        start_load = 1'b1;
        state_d    = LOAD_W;
      end
      LOAD_W: if (s_valid) begin
        accept_w = 1'b1;
        if (last_w_beat) state_d = LOAD_I;
      end
      LOAD_I: if (s_valid) begin
        accept_i = 1'b1;
        if (at_last_slot && last_i_word) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Address counters and registered weight-port outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_cnt    <= '0;
      i_cnt    <= '0;
      wb_ena   <= 1'b0;
      wb_wea   <= '0;
      wb_addra <= '0;
      wb_dina  <= '0;
      in_addra <= '0;
    end else begin
      wb_ena <= accept_w;
      wb_wea <= {WE_W{accept_w}};
      if (start_load) begin
        w_cnt <= '0;
        i_cnt <= '0;
      end else begin
        if (accept_w) begin
          wb_addra <= w_cnt;
          wb_dina  <= s_data;
          w_cnt    <= w_cnt + 1'b1;
        end
        if (word_done) begin
          in_addra <= i_cnt;
          i_cnt    <= i_cnt + 1'b1;
        end
      end
    end
  end

  core_word_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .clear        (pack_clear),
    .beat_valid   (accept_i),
    .beat         (s_data),
    .at_last_slot (at_last_slot),
    .word_valid   (in_ena),
    .word         (in_dina)
  );

  assign in_wea = {WE_W{in_ena}};

  // start follows DONE one cycle late and drops on the cycle after a new request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) start <= 1'b0;
    else     start <= (state_q == DONE) && !load_req;
  end

`ifdef LOADER_LAST_CHECK_EN
  // Sticky framing error: s_last must be high on exactly the final beat of a load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                                err <= 1'b0;
    else if (start_load)                                    err <= 1'b0;
    else if ((accept_w || accept_i) && (s_last != final_beat)) err <= 1'b1;
  end
`else
  logic unused_framing;
  assign unused_framing = s_last ^ final_beat;
  assign err            = 1'b0;
`endif

endmodule
